// File: rtl/seq_add64_ctrl_if.sv
// Valid/ready operand and result channels for seq_add64_ctrl.
// SEQ_ADD64_SUB_EN adds the sub request bit to the operand channel.
interface seq_add64_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SEQ_ADD64_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output in_valid, a, b, c_in, out_ready,
`ifdef SEQ_ADD64_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
`ifdef SEQ_ADD64_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/seq_add64_ctrl.sv
// Multi-cycle WIDTH-bit adder reusing one SLICE_W ripple-carry slice, LSB slice first.
// Define SEQ_ADD64_SUB_EN to add the sub request (a - b, c_out=1 means no borrow).

module seq_add64_rca_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sum  = '0;
        c    = '0;
        c[0] = cin;
        // NOTE: blocking assignments here so each bit sees the carry computed by the previous iteration.
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[W];
    end
endmodule

module seq_add64_ctrl #(
    parameter int WIDTH   = 64,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    seq_add64_ctrl_if.slave   bus,
    output logic              busy
);
    localparam int BEATS = WIDTH / SLICE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((WIDTH % SLICE_W) != 0) begin : g_bad_width
        $error("seq_add64_ctrl: WIDTH must be a multiple of SLICE_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             c_out_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_carry;

    // Subtraction is a + ~b + 1, so it reuses the adder by conditioning the stored operand and seed carry.
    always_comb begin
        b_load     = bus.b;
        carry_load = bus.c_in;
`ifdef SEQ_ADD64_SUB_EN
        if (bus.sub) begin
            b_load     = ~bus.b;
            carry_load = 1'b1;
        end
`endif
    end

    always_comb begin
        slice_a = a_reg[beat*SLICE_W +: SLICE_W];
        slice_b = b_reg[beat*SLICE_W +: SLICE_W];
    end

    seq_add64_rca_slice #(
        .W (SLICE_W)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: a_reg/b_reg are left out of reset; they are always loaded on accept before being read.
            state         <= IDLE;
            beat          <= '0;
            carry_reg     <= 1'b0;
            sum_reg       <= '0;
            c_out_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= b_load;
                        carry_reg <= carry_load;
                        beat      <= '0;
                        busy_reg  <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[beat*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_reg                        <= slice_carry;
                    if (beat == LAST_BEAT) begin
                        beat          <= '0;
                        c_out_reg     <= slice_carry;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // in_ready depends only on state and rst, never on in_valid or out_ready.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.c_out     = c_out_reg;
    assign busy          = busy_reg;
endmodule

// File: doc/seq_add64_ctrl.md
# seq_add64_ctrl

Multi-cycle controller that computes a 64-bit add by time-multiplexing one 16-bit ripple-carry slice over four beats, least-significant slice first. A registered carry links the beats. It sits between a requester issuing 64-bit operand pairs and a consumer of the 64-bit result, trading latency for a quarter of the full-width ripple adder area. Both sides use valid/ready handshakes.

## Interface
Parameters:
- WIDTH, 64, total operand width; must be an integer multiple of SLICE_W.
- SLICE_W, 16, width of the single internal ripple-carry slice. At 16 the slice is the team's existing 16-bit ripple-carry module.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  requester presents an operand pair.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- c_in  input  1  carry into bit 0, sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result this cycle.
- sum  output  WIDTH  registered result.
- c_out  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

## Operation
- BEATS = WIDTH/SLICE_W (4 at defaults). A beat counter counts 0..BEATS-1.
- States:
  - IDLE: in_ready=1. On in_valid, register a, b and c_in into the operand registers and the carry register, clear the counter, and go to RUN.
  - RUN: the slice adds a_reg[beat*SLICE_W +: SLICE_W] + b_reg[same] + carry_reg. The slice sum is written into the matching sum_reg field, the slice carry into carry_reg, and the counter increments. When beat = BEATS-1, load c_out from the slice carry and go to DONE.
  - DONE: out_valid=1. sum and c_out are held stable. On out_ready, go to IDLE.
- in_ready is low in RUN and DONE. in_valid is ignored there; operands are not queued.
- Arithmetic is modulo 2^WIDTH with carry-out, identical to a full-width ripple-carry add of a+b+c_in.
- sum fields not yet written in RUN keep their previous value. sum is only architecturally valid while out_valid=1.
- Reset: in any state, state goes to IDLE, counter to 0, carry_reg to 0, sum to 0, c_out to 0 and out_valid to 0. An in-flight operation is discarded with no output. While rst=1, in_ready=0.

## Timing
- Accept on edge T (in_valid & in_ready). RUN occupies edges T+1..T+BEATS, and out_valid rises after edge T+BEATS (4 cycles at defaults).
- Result handshake completes on the edge where out_valid & out_ready. in_ready is high the following cycle.
- Peak throughput is one operation per BEATS+2 cycles: accept, BEATS run cycles, and at least one DONE cycle.
- out_valid, sum, c_out and busy are registered or state-decoded. in_ready is a decode of state and rst. There is no combinational path from in_valid or out_ready to any output.
- If out_ready is already high on entry to DONE, the result is consumed on the first DONE edge.

## Configuration
- SEQ_ADD64_SUB_EN defined:
  - Adds input port sub (1 bit), sampled on accept.
  - When sub=1, the block stores ~b, seeds carry_reg with 1 and ignores c_in, so the result is a-b.
  - c_out=1 means no borrow.
- SEQ_ADD64_SUB_EN undefined: the sub port is absent and the block only adds.

## Test plan
- a=0xFFFF_FFFF_FFFF_FFFF, b=1, c_in=0 -> sum=0, c_out=1. out_valid rises exactly 4 cycles after the accept edge.
- a=0x0000_0000_0000_FFFF, b=1, c_in=0 -> sum=0x0000_0000_0001_0000, c_out=0, proving carry propagation across the slice boundary.
- Hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> sum and out_valid stable and in_ready=0 throughout. After out_ready=1, the new operands are accepted the next cycle.
- Assert rst for one cycle during RUN beat 2 -> the next cycle shows IDLE, out_valid=0, sum=0, in_ready=1, and no stale result ever appears.
- With SEQ_ADD64_SUB_EN:
  - a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0.
  - a=7, b=5, sub=1 -> sum=2, c_out=1.
- 1000 back-to-back random (a, b, c_in) triples with random out_ready stalls -> every result matches a behavioural model of a+b+c_in, with no drops or duplicates.
